// File: rtl/trend_pkg.sv
// rtl/trend_pkg.sv - shared state/class encodings and counter widths for the trend detector
package trend_pkg;

    typedef enum logic [1:0] {
        ST_FLAT  = 2'b00,
        ST_LONG  = 2'b01,
        ST_SHORT = 2'b10
    } trend_state_e;

    typedef enum logic [1:0] {
        CLS_INSIDE = 2'b00,
        CLS_ABOVE  = 2'b01,
        CLS_BELOW  = 2'b10
    } trend_class_e;

    localparam int CONFIRM_W = 4;
    localparam int WARMUP_W  = 8;
    localparam int TRADE_W   = 16;

endpackage

// File: rtl/trend_sat_counter.sv
// rtl/trend_sat_counter.sv - saturating up-counter with synchronous clear
module trend_sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // clear together with enable restarts the count at 1 rather than 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= {{(WIDTH-1){1'b0}}, i_enable};
        end else if (i_enable && (r_count != MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/trend_signal_detector.sv
// rtl/trend_signal_detector.sv - price vs moving-average trend FSM with hysteresis and confirmation
module trend_signal_detector
    import trend_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MA_SHIFT = 0,
    parameter int CONFIRM  = 3,
    parameter int WARMUP   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] price_in,
    input  logic [WIDTH+3:0] ma_in,
    input  logic [WIDTH-1:0] thresh,
    output logic             out_valid,
    output logic [WIDTH+4:0] diff_out,
    output logic [1:0]       state,
    output logic             buy_pulse,
    output logic             sell_pulse,
    output logic [15:0]      trade_count
);

    localparam int DW = WIDTH + 5;

    logic signed [WIDTH+3:0] w_ma_aligned;
    logic signed [DW-1:0]    w_price_ext;
    logic signed [DW-1:0]    w_ma_ext;
    logic signed [DW-1:0]    w_diff;
    logic signed [DW-1:0]    w_th_pos;
    logic signed [DW-1:0]    w_th_neg;
    trend_class_e            w_class;

    assign w_ma_aligned = $signed(ma_in) >>> MA_SHIFT;
    assign w_price_ext  = {{5{price_in[WIDTH-1]}}, price_in};
    assign w_ma_ext     = {w_ma_aligned[WIDTH+3], w_ma_aligned};
    assign w_diff       = w_price_ext - w_ma_ext;
    assign w_th_pos     = {5'b0, thresh};
    assign w_th_neg     = -w_th_pos;

    always_comb begin
        w_class = CLS_INSIDE;
        if (w_diff > w_th_pos) begin
            w_class = CLS_ABOVE;
        end else if (w_diff < w_th_neg) begin
            w_class = CLS_BELOW;
        end
    end

    trend_state_e            r_state;
    trend_state_e            w_state_next;
    trend_class_e            r_cand;
    logic                    r_out_valid;
    logic [DW-1:0]           r_diff;
    logic                    r_buy;
    logic                    r_sell;

    logic [WARMUP_W-1:0]     w_warm_cnt;
    logic                    w_warm_done;
    logic [CONFIRM_W-1:0]    w_conf_cnt;
    logic [TRADE_W-1:0]      w_trade_cnt;

    logic                    w_active;
    logic                    w_agree;
    logic                    w_counting;
    logic                    w_reversal;
    logic [CONFIRM_W:0]      w_next_cnt;
    logic                    w_conf_clear;
    logic                    w_conf_en;
    logic                    w_buy_next;
    logic                    w_sell_next;
    logic                    w_fire;

    assign w_warm_done = (w_warm_cnt == WARMUP_W'(WARMUP));
    assign w_active    = in_valid && w_warm_done;
    assign w_agree     = ((r_state == ST_LONG)  && (w_class == CLS_ABOVE)) ||
                         ((r_state == ST_SHORT) && (w_class == CLS_BELOW));

    trend_sat_counter #(
        .WIDTH (WARMUP_W),
        .MAX   (WARMUP_W'(WARMUP))
    ) u_warmup_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (1'b0),
        .i_enable (in_valid && !w_warm_done),
        .o_count  (w_warm_cnt)
    );

    trend_sat_counter #(
        .WIDTH (CONFIRM_W),
        .MAX   ({CONFIRM_W{1'b1}})
    ) u_confirm_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_conf_clear),
        .i_enable (w_conf_en),
        .o_count  (w_conf_cnt)
    );

    trend_sat_counter #(
        .WIDTH (TRADE_W),
        .MAX   ({TRADE_W{1'b1}})
    ) u_trade_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (1'b0),
        .i_enable (w_fire),
        .o_count  (w_trade_cnt)
    );

    // A sample opposing the state (or either direction in FLAT) advances the streak;
    // switching candidate direction restarts the streak at this sample.
    always_comb begin
        w_state_next = r_state;
        w_counting   = 1'b0;
        w_reversal   = 1'b0;
        w_next_cnt   = '0;
        w_conf_clear = 1'b0;
        w_conf_en    = 1'b0;
        w_buy_next   = 1'b0;
        w_sell_next  = 1'b0;
        w_fire       = 1'b0;
        if (w_active) begin
            if ((w_class == CLS_INSIDE) || w_agree) begin
                w_conf_clear = 1'b1;
            end else begin
                w_counting = 1'b1;
                w_reversal = (w_conf_cnt != '0) && (r_cand != w_class);
                w_next_cnt = w_reversal ? (CONFIRM_W+1)'(1)
                                        : {1'b0, w_conf_cnt} + (CONFIRM_W+1)'(1);
                if (w_next_cnt >= (CONFIRM_W+1)'(CONFIRM)) begin
                    w_fire       = 1'b1;
                    w_conf_clear = 1'b1;
                    if (w_class == CLS_ABOVE) begin
                        w_state_next = ST_LONG;
                        w_buy_next   = 1'b1;
                    end else begin
                        w_state_next = ST_SHORT;
                        w_sell_next  = 1'b1;
                    end
                end else begin
                    w_conf_clear = w_reversal;
                    w_conf_en    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FLAT;
            r_cand      <= CLS_INSIDE;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_buy       <= 1'b0;
            r_sell      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= in_valid;
            r_buy       <= w_buy_next;
            r_sell      <= w_sell_next;
            if (in_valid) begin
                r_diff <= w_diff;
            end
            if (w_counting) begin
                r_cand <= w_class;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign diff_out    = r_diff;
    assign state       = r_state;
    assign buy_pulse   = r_buy;
    assign sell_pulse  = r_sell;
    assign trade_count = w_trade_cnt;

endmodule

// File: doc/trend_signal_detector.md
TREND_SIGNAL_DETECTOR -- requirements
Module: trend_signal_detector

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the price sample width (signed).
REQ-002 SHALL have parameter MA_SHIFT, default 0, the arithmetic right shift applied to ma_in to align it to price scale.
REQ-003 SHALL have parameter CONFIRM, default 3, the consecutive qualifying samples needed for a state change (range 1..15).
REQ-004 SHALL have parameter WARMUP, default 8, the valid samples ignored after reset while the upstream FIR fills (range 0..255).
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  the reset, synchronous and active-high.
REQ-007 SHALL have port in_valid  input  1  price_in/ma_in/thresh valid this cycle.
REQ-008 SHALL have port price_in  input  WIDTH  the signed raw price sample.
REQ-009 SHALL have port ma_in  input  WIDTH+4  the signed FIR filter output (y_out) for the same sample.
REQ-010 SHALL have port thresh  input  WIDTH  the unsigned hysteresis band half-width.
REQ-011 SHALL have port out_valid  output  1  pulses one cycle after each accepted in_valid.
REQ-012 SHALL have port diff_out  output  WIDTH+5  the signed registered difference (price minus aligned MA).
REQ-013 SHALL have port state  output  2  trend state: FLAT=00, LONG=01, SHORT=10.
REQ-014 SHALL have ports buy_pulse and sell_pulse  output  1  one-cycle trade event strobes.
REQ-015 SHALL have port trade_count  output  16  the saturating count of trade events.

Function
REQ-016 diff SHALL equal sign-extended price_in minus sign-extended (ma_in >>> MA_SHIFT), computed at WIDTH+5 bits with no saturation.
REQ-017 A sample SHALL classify ABOVE if diff > thresh, BELOW if diff < -thresh, otherwise INSIDE (thresh=0: diff==0 is INSIDE).
REQ-018 Cycles with in_valid=0 SHALL hold all state, counters and diff_out; out_valid, buy_pulse and sell_pulse SHALL be 0.
REQ-019 Latency SHALL be 1 cycle: diff_out, state, out_valid and pulses update at the edge that samples in_valid=1.
REQ-020 The first WARMUP valid samples after reset SHALL update diff_out and out_valid only; classification SHALL be ignored and the confirm counter held at 0.
REQ-021 Warmup counter SHALL saturate at WARMUP and not restart until reset.
REQ-022 FSM: FLAT->LONG after CONFIRM consecutive ABOVE; FLAT->SHORT after CONFIRM consecutive BELOW; LONG->SHORT after CONFIRM consecutive BELOW; SHORT->LONG after CONFIRM consecutive ABOVE; no return to FLAT except reset.
REQ-023 Confirm counter SHALL clear on any valid sample that is INSIDE, agrees with current state, or reverses the candidate direction; idle cycles SHALL NOT clear it.
REQ-024 In FLAT, a reversal (ABOVE then BELOW) SHALL restart the count at 1 for the new direction.
REQ-025 Entering LONG SHALL assert buy_pulse for exactly one cycle; entering SHORT SHALL assert sell_pulse for one cycle; never both.
REQ-026 trade_count SHALL increment by 1 per pulse and saturate at 16'hFFFF.
REQ-027 Confirm counter SHALL clear on every transition.

Reset
REQ-028 On rst=1 at an edge: state=FLAT, diff_out=0, out_valid=0, pulses=0, trade_count=0, confirm and warmup counters=0.
REQ-029 Reset SHALL take priority over in_valid; reset mid-confirmation SHALL discard partial counts and restart warmup.

Structure
REQ-030 State encodings and the ABOVE/BELOW/INSIDE class codes SHALL live in shared package trend_pkg.
REQ-031 One sub-module trend_sat_counter (parameterised width, enable, clear, saturation) SHALL implement the warmup, confirm and trade counters.

Verification (WIDTH=16, MA_SHIFT=0, CONFIRM=3, WARMUP=8, thresh=20 unless stated)
REQ-032 Reset: hold rst 3 cycles -> state=00, trade_count=0, all strobes 0.
REQ-033 Warmup+buy: 11 samples price=10100, ma=10000 -> diff_out=100, no pulse for samples 1..10, buy_pulse one cycle after sample 11, state=01, trade_count=1.
REQ-034 Band: after warmup, price=10020/ma=10000 and price=9980/ma=10000 repeated 10 times -> diff_out=20/-20, state stays 00.
REQ-035 Interrupted: in LONG, BELOW,BELOW,INSIDE,BELOW,BELOW -> no change; one more BELOW -> sell_pulse, state=10, trade_count=2.
REQ-036 Gaps+reset: BELOW with 5 idle cycles between -> gaps don't clear count; rst after 2 ABOVE in SHORT -> state=00, count cleared, warmup restarts.
REQ-037 Alignment: MA_SHIFT=2, ma_in=40000, price_in=10000 -> diff_out=0, INSIDE.
